// File: rtl/serial_link_pkg.sv
// ============================================================================
// Module : serial_link_pkg
// Brief  : Shared types and sizing for the serial link credit flow control.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_link_pkg;

    localparam int unsigned NumCredits  = 16;
    localparam int unsigned CreditWidth = $clog2(NumCredits + 1);

    typedef logic [CreditWidth-1:0] credit_t;

    typedef enum logic [1:0] {
        CrIdle    = 2'd0,
        CrPending = 2'd1,
        CrForce   = 2'd2
    } credit_state_e;

endpackage

`default_nettype wire

// File: rtl/serial_link_credit_return_timer.sv
// ============================================================================
// Module : serial_link_credit_return_timer
// Brief  : Up-counter with synchronous clear (priority) and count enable.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_link_credit_return_timer #(
    parameter int unsigned Width = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + Width'(1);
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/serial_link_credit_return.sv
// ============================================================================
// Module : serial_link_credit_return
// Brief  : Receiver-side credit return: counts freed RX slots and offers them
//          to the TX link layer, forcing a credit-only flit when needed.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_link_credit_return
    import serial_link_pkg::*;
#(
    parameter int unsigned NumCredits  = serial_link_pkg::NumCredits,
    parameter int unsigned ForceThresh = NumCredits / 2,
    parameter int unsigned IdleTimeout = 64
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    clear_i,
    input  logic    rx_push_i,
    input  logic    rx_pop_i,
    output credit_t credits_o,
    output logic    credits_valid_o,
    input  logic    credits_ready_i,
    output logic    force_send_o,
    output credit_t occupancy_o,
    output logic    overflow_o,
    output logic    underflow_o
);

    localparam credit_t     FullLvl    = credit_t'(NumCredits);
    localparam credit_t     ThreshLvl  = credit_t'(ForceThresh);
    localparam int unsigned TimerWidth = $clog2(IdleTimeout);
    localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(IdleTimeout - 1);

    credit_state_e state_q, state_d;
    credit_t       pending_q, pending_d;
    credit_t       offered_q, offered_d;
    credit_t       occupancy_q, occupancy_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic                  push_ok, pop_ok;
    logic                  handshake;
    credit_t               pending_base;
    logic [CreditWidth:0]  pending_sum;
    credit_t               pending_next;
    logic                  timer_clr, timer_en;
    logic [TimerWidth-1:0] timer_q;

    // ------------------------------------------------------------------
    // Buffer occupancy and error tracking. A push and pop in the same
    // cycle cancel out, so they are legal even at empty or full.
    // ------------------------------------------------------------------
    always_comb begin
        push_ok     = rx_push_i && ((occupancy_q != FullLvl) || rx_pop_i);
        pop_ok      = rx_pop_i  && ((occupancy_q != '0) || rx_push_i);
        occupancy_d = occupancy_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_ok && !pop_ok) begin
            occupancy_d = occupancy_q + credit_t'(1);
        end else if (pop_ok && !push_ok) begin
            occupancy_d = occupancy_q - credit_t'(1);
        end

        if (rx_push_i && !rx_pop_i && (occupancy_q == FullLvl)) begin
            overflow_d = 1'b1;
        end
        if (rx_pop_i && !rx_push_i && (occupancy_q == '0)) begin
            underflow_d = 1'b1;
        end

        if (clear_i) begin
            occupancy_d = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Pending credits: the handshake retires what was offered, while a
    // pop in the same cycle still adds to the residual.
    // ------------------------------------------------------------------
    always_comb begin
        handshake    = (state_q != CrIdle) && credits_ready_i;
        pending_base = handshake ? (pending_q - offered_q) : pending_q;
        pending_sum  = {1'b0, pending_base} + {{CreditWidth{1'b0}}, pop_ok};
        if (pending_sum > {1'b0, FullLvl}) begin
            pending_next = FullLvl;
        end else begin
            pending_next = pending_sum[CreditWidth-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Offer FSM. The offered value is relatched whenever a new offer
    // starts so credits_o never changes under a stalled valid.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        offered_d = offered_q;
        pending_d = pending_next;
        timer_clr = 1'b0;
        timer_en  = 1'b0;

        case (state_q)
            CrIdle: begin
                timer_clr = 1'b1;
                if (pending_next != '0) begin
                    state_d   = CrPending;
                    offered_d = pending_next;
                end
            end
            CrPending: begin
                if (handshake) begin
                    timer_clr = 1'b1;
                    if (pending_next == '0) begin
                        state_d   = CrIdle;
                        offered_d = '0;
                    end else begin
                        offered_d = pending_next;
                    end
                end else begin
                    timer_en = 1'b1;
                    if ((pending_q >= ThreshLvl) || (timer_q == TimerLast)) begin
                        state_d = CrForce;
                    end
                end
            end
            CrForce: begin
                if (handshake) begin
                    timer_clr = 1'b1;
                    if (pending_next == '0) begin
                        state_d   = CrIdle;
                        offered_d = '0;
                    end else begin
                        state_d   = CrPending;
                        offered_d = pending_next;
                    end
                end
            end
            default: begin
                state_d   = CrIdle;
                offered_d = '0;
                timer_clr = 1'b1;
            end
        endcase

        if (clear_i) begin
            state_d   = CrIdle;
            pending_d = '0;
            offered_d = '0;
            timer_clr = 1'b1;
            timer_en  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= CrIdle;
            pending_q   <= '0;
            offered_q   <= '0;
            occupancy_q <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            offered_q   <= offered_d;
            occupancy_q <= occupancy_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    serial_link_credit_return_timer #(
        .Width (TimerWidth)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (timer_clr),
        .en_i    (timer_en),
        .count_o (timer_q)
    );

    assign credits_o       = offered_q;
    assign credits_valid_o = (state_q != CrIdle);
    assign force_send_o    = (state_q == CrForce);
    assign occupancy_o     = occupancy_q;
    assign overflow_o      = overflow_q;
    assign underflow_o     = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_link_credit_return.sv
// ============================================================================
// Module : tb_serial_link_credit_return
// Brief  : Self-checking bench with a cycle-level credit model and directed vectors.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_link_credit_return;
    import serial_link_pkg::*;

    localparam int FULL    = 16;
    localparam int THRESH  = 8;
    localparam int TIMEOUT = 64;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    logic    clr = 1'b0, push = 1'b0, pop = 1'b0, ready = 1'b0;
    credit_t credits, occupancy;
    logic    valid, force_send, overflow, underflow;

    int checks = 0;
    int errors = 0;

    serial_link_credit_return dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .clear_i         (clr),
        .rx_push_i       (push),
        .rx_pop_i        (pop),
        .credits_o       (credits),
        .credits_valid_o (valid),
        .credits_ready_i (ready),
        .force_send_o    (force_send),
        .occupancy_o     (occupancy),
        .overflow_o      (overflow),
        .underflow_o     (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: buffer fill, freed-but-unreturned credits, and the current offer.
    int m_occ, m_pend, m_off, m_age, m_freed, m_new;
    bit m_valid, m_force, m_ovf, m_udf, m_hs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            m_occ = 0; m_pend = 0; m_off = 0; m_age = 0;
            m_valid = 0; m_force = 0; m_ovf = 0; m_udf = 0;
        end else begin
            m_freed = 0;
            if (push && pop) m_freed = 1;
            else if (push) begin
                if (m_occ == FULL) m_ovf = 1; else m_occ++;
            end else if (pop) begin
                if (m_occ == 0) m_udf = 1; else begin m_occ--; m_freed = 1; end
            end
            m_hs  = m_valid && ready;
            m_new = m_pend - (m_hs ? m_off : 0) + m_freed;
            if (m_new > FULL) m_new = FULL;
            if (!m_valid) begin
                if (m_new > 0) begin m_valid = 1; m_off = m_new; m_age = 0; end
            end else if (m_hs) begin
                m_force = 0; m_age = 0;
                if (m_new == 0) begin m_valid = 0; m_off = 0; end
                else m_off = m_new;
            end else if (!m_force) begin
                if (m_pend >= THRESH || m_age == TIMEOUT - 1) m_force = 1;
                else m_age++;
            end
            m_pend = m_new;
        end
    end

    always @(negedge clk) begin
        check("credits",   int'(credits),   m_valid ? m_off : 0);
        check("valid",     int'(valid),     int'(m_valid));
        check("force",     int'(force_send), int'(m_force));
        check("occupancy", int'(occupancy), m_occ);
        check("overflow",  int'(overflow),  int'(m_ovf));
        check("underflow", int'(underflow), int'(m_udf));
    end

    task automatic step(input bit pu, input bit po, input bit rd, input bit cl);
        push = pu; pop = po; ready = rd; clr = cl;
        @(posedge clk); #2;
        push = 0; pop = 0; ready = 0; clr = 0;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_credits"}, int'(credits), 0);
        check({nm, "_valid"}, int'(valid), 0);
        check({nm, "_force"}, int'(force_send), 0);
        check({nm, "_occ"}, int'(occupancy), 0);
        check({nm, "_ovf"}, int'(overflow), 0);
        check({nm, "_udf"}, int'(underflow), 0);
    endtask

    initial begin
        int n;
        #3;
        check_all_zero("reset");
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;

        // Fill 10 slots, then return credits with a stalled TX layer.
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
        check("occ_after_fill", int'(occupancy), 10);
        check("idle_valid", int'(valid), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        check("first_offer_valid", int'(valid), 1);
        check("first_offer_held", int'(credits), 1);
        step(0, 1, 1, 0);
        check("residual_offer", int'(credits), 3);
        check("residual_valid", int'(valid), 1);
        step(0, 0, 1, 0);
        check("drained_valid", int'(valid), 0);
        check("drained_credits", int'(credits), 0);

        // Threshold forcing.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
        check("thresh_not_yet", int'(force_send), 0);
        step(0, 0, 0, 0);
        check("thresh_force", int'(force_send), 1);
        step(0, 0, 1, 0);
        check("thresh_hs_force", int'(force_send), 0);
        check("thresh_hs_credits", int'(credits), 7);
        step(0, 0, 1, 0);
        check("thresh_idle", int'(valid), 0);

        // Idle timeout forcing.
        step(0, 1, 0, 0);
        check("tmo_valid", int'(valid), 1);
        n = 0;
        while (!force_send && n < 200) begin
            step(0, 0, 0, 0);
            n++;
        end
        check("timeout_latency", n, TIMEOUT);
        step(0, 0, 1, 0);
        check("tmo_idle", int'(valid), 0);

        // Overflow at full, push&pop at full.
        for (int i = 0; i < 11; i++) step(1, 0, 0, 0);
        check("occ_full", int'(occupancy), FULL);
        step(1, 0, 0, 0);
        check("overflow_set", int'(overflow), 1);
        check("occ_saturated", int'(occupancy), FULL);
        step(1, 1, 0, 0);
        check("occ_pushpop_full", int'(occupancy), FULL);

        // Clear, underflow, push&pop at empty, clear priority.
        step(0, 0, 0, 1);
        check_all_zero("clear");
        step(0, 1, 0, 0);
        check("underflow_set", int'(underflow), 1);
        check("underflow_no_credit", int'(valid), 0);
        step(1, 1, 0, 0);
        check("occ_pushpop_empty", int'(occupancy), 0);
        check("pushpop_empty_credit", int'(credits), 1);
        step(1, 1, 1, 1);
        check_all_zero("clear_prio");

        // Asynchronous reset while forcing.
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check("pre_reset_force", int'(force_send), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk); #2;
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        check("post_reset_idle", int'(valid), 0);

        // Mixed traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 120; i++)
            step(i % 3 != 0, i % 2 == 0, i % 5 == 1, i == 90);

        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
